// File: rtl/instr_prefetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : instr_prefetch
// Brief    : Instruction fetch front end. Issues word fetches over a
//            valid/ready request + in-order response port, buffers words
//            with their PC in a DEPTH-entry FIFO and hands them to decode.
//            Redirects flush the FIFO and discard stale in-flight responses.
// Revision : 1.0 - initial release
// ============================================================================
module instr_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  output logic        instr_valid,
  output logic [31:0] instr_data,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef enum logic [0:0] {
    ST_RUN   = 1'b0,
    ST_DRAIN = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic          run_en_q;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] drop_cnt_q, drop_cnt_d;
  logic [CW-1:0] fifo_count_q, fifo_count_d;

  // Instruction FIFO (data + PC) and the in-order PC tag queue of live requests
  logic [31:0]   fifo_data_q [DEPTH];
  logic [31:0]   fifo_pc_q   [DEPTH];
  logic [AW-1:0] fifo_wr_q, fifo_rd_q;
  logic [31:0]   pcq_q       [DEPTH];
  logic [AW-1:0] pcq_wr_q, pcq_rd_q;

  logic          w_draining;
  logic          w_req_fire;
  logic          w_fifo_push;
  logic          w_rsp_drop;
  logic          w_fifo_pop;
  logic [CW:0]   w_credit_used;
  logic          w_unused;

  // Byte-offset bits of the redirect target are architecturally ignored
  assign w_unused = &redirect_pc[1:0];

  assign w_draining    = (state_q == ST_DRAIN);
  // Buffered plus in-flight words bound the FIFO occupancy, so it can never overflow
  assign w_credit_used = {1'b0, fifo_count_q} + {1'b0, outstanding_q};
  assign mem_req_valid = run_en_q && (w_credit_used < (CW+1)'(DEPTH)) && !redirect_valid;
  assign mem_req_addr  = fetch_pc_q;
  assign w_req_fire    = mem_req_valid && mem_req_ready;
  assign w_fifo_push   = mem_rsp_valid && !w_draining && !redirect_valid;
  assign w_rsp_drop    = mem_rsp_valid && w_draining && !redirect_valid;
  assign instr_valid   = (fifo_count_q != '0);
  assign w_fifo_pop    = instr_valid && instr_ready && !redirect_valid;
  assign instr_data    = fifo_data_q[fifo_rd_q];
  assign instr_pc      = fifo_pc_q[fifo_rd_q];

  // Next-state for fetch pointer, credit counters and drain FSM
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    outstanding_d = outstanding_q;
    drop_cnt_d    = drop_cnt_q;
    fifo_count_d  = fifo_count_q;
    if (redirect_valid) begin
      // Everything still in flight after this cycle belongs to the old path
      fetch_pc_d    = {redirect_pc[31:2], 2'b00};
      outstanding_d = outstanding_q - CW'(mem_rsp_valid);
      drop_cnt_d    = outstanding_d;
      fifo_count_d  = '0;
    end else begin
      if (w_req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      outstanding_d = outstanding_q + CW'(w_req_fire) - CW'(mem_rsp_valid);
      if (w_rsp_drop) begin
        drop_cnt_d = drop_cnt_q - CW'(1);
      end
      fifo_count_d = fifo_count_q + CW'(w_fifo_push) - CW'(w_fifo_pop);
    end
    state_d = (drop_cnt_d != '0) ? ST_DRAIN : ST_RUN;
  end

  // All sequential state: pointer, counters, FSM, FIFO storage and PC tag queue
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_en_q      <= 1'b0;
      state_q       <= ST_RUN;
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= '0;
      drop_cnt_q    <= '0;
      fifo_count_q  <= '0;
      fifo_wr_q     <= '0;
      fifo_rd_q     <= '0;
      pcq_wr_q      <= '0;
      pcq_rd_q      <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_data_q[i] <= '0;
        fifo_pc_q[i]   <= '0;
        pcq_q[i]       <= '0;
      end
    end else begin
      run_en_q      <= 1'b1;
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      outstanding_q <= outstanding_d;
      drop_cnt_q    <= drop_cnt_d;
      fifo_count_q  <= fifo_count_d;
      if (redirect_valid) begin
        fifo_wr_q <= '0;
        fifo_rd_q <= '0;
        pcq_wr_q  <= '0;
        pcq_rd_q  <= '0;
      end else begin
        if (w_req_fire) begin
          pcq_q[pcq_wr_q] <= fetch_pc_q;
          pcq_wr_q        <= pcq_wr_q + AW'(1);
        end
        if (w_fifo_push) begin
          fifo_data_q[fifo_wr_q] <= mem_rsp_data;
          fifo_pc_q[fifo_wr_q]   <= pcq_q[pcq_rd_q];
          fifo_wr_q              <= fifo_wr_q + AW'(1);
          pcq_rd_q               <= pcq_rd_q + AW'(1);
        end
        if (w_fifo_pop) begin
          fifo_rd_q <= fifo_rd_q + AW'(1);
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instr_prefetch.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_instr_prefetch
// Brief    : Self-checking bench for instr_prefetch: in-order memory model,
//            expected-PC scoreboard and credit model with stale tracking.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_prefetch;

  localparam int unsigned DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready = 1'b0;
  logic        mem_rsp_valid = 1'b0;
  logic [31:0] mem_rsp_data = '0;
  logic        instr_valid;
  logic [31:0] instr_data;
  logic [31:0] instr_pc;
  logic        instr_ready = 1'b0;

  instr_prefetch #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .mem_req_valid  (mem_req_valid),
    .mem_req_addr   (mem_req_addr),
    .mem_req_ready  (mem_req_ready),
    .mem_rsp_valid  (mem_rsp_valid),
    .mem_rsp_data   (mem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_data     (instr_data),
    .instr_pc       (instr_pc),
    .instr_ready    (instr_ready)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Memory contents as a pure function of address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_txn_t;

  mem_txn_t    memq[$];
  logic [31:0] expq[$];
  int          cyc = 0;
  int          rsp_lat = 1;
  int          stale = 0;
  int          since_rst = 0;
  int          pop_cnt = 0;
  int          req_cnt = 0;
  logic [31:0] model_pc = RESET_PC;
  logic [31:0] first_req_addr = '0;
  logic [31:0] cap_pc [4];
  int          cap_idx = 4;
  logic        redir_prev = 1'b0;

  // In-order memory: presents the oldest accepted request once its latency expires
  always @(posedge clk) begin
    cyc = cyc + 1;
    #1;
    if (rst_n && memq.size() > 0 && memq[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_word(memq[0].addr);
    end else begin
      mem_rsp_valid = 1'b0;
      mem_rsp_data  = '0;
    end
  end

  // Mid-cycle monitor: credit model, request address model and instruction scoreboard
  always @(negedge clk) begin
    if (!rst_n) begin
      memq.delete();
      expq.delete();
      stale      = 0;
      since_rst  = 0;
      req_cnt    = 0;
      model_pc   = RESET_PC;
      redir_prev = 1'b0;
    end else begin
      if (since_rst >= 1)
        check_eq("req_credit", 32'(mem_req_valid),
                 32'(((expq.size() + stale) < int'(DEPTH)) && !redirect_valid));
      if (redir_prev)
        check_eq("flush_empty", 32'(instr_valid), 32'd0);
      redir_prev = redirect_valid;
      if (redirect_valid) begin
        stale = memq.size() - (mem_rsp_valid ? 1 : 0);
        if (mem_rsp_valid) void'(memq.pop_front());
        expq.delete();
        model_pc = {redirect_pc[31:2], 2'b00};
      end else begin
        if (mem_req_valid && mem_req_ready) begin
          check_eq("req_addr", mem_req_addr, model_pc);
          if (req_cnt == 0) first_req_addr = mem_req_addr;
          req_cnt++;
          expq.push_back(model_pc);
          memq.push_back('{addr: model_pc, due: cyc + rsp_lat});
          model_pc = model_pc + 32'd4;
        end
        if (mem_rsp_valid) begin
          void'(memq.pop_front());
          if (stale > 0) stale--;
        end
        if (instr_valid && instr_ready) begin
          check_eq("pop_expected", 32'(expq.size() > 0), 32'd1);
          if (expq.size() > 0) begin
            check_eq("instr_pc", instr_pc, expq[0]);
            check_eq("instr_data", instr_data, mem_word(expq[0]));
            void'(expq.pop_front());
          end
          pop_cnt++;
          if (cap_idx < 4) begin
            cap_pc[cap_idx] = instr_pc;
            cap_idx++;
          end
        end
      end
      since_rst++;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
  endtask

  task automatic redirect_to(input logic [31:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick(1);
    redirect_valid = 1'b0;
  endtask

  initial begin
    int p0;
    int r0;
    int w;
    rst_n         = 1'b0;
    mem_req_ready = 1'b1;
    instr_ready   = 1'b1;
    rsp_lat       = 1;
    tick(3);
    check_eq("rst_req_valid", 32'(mem_req_valid), 32'd0);
    check_eq("rst_instr_valid", 32'(instr_valid), 32'd0);
    check_eq("rst_req_addr", mem_req_addr, RESET_PC);
    check_eq("rst_instr_data", instr_data, 32'd0);
    check_eq("rst_instr_pc", instr_pc, 32'd0);

    // Sustained streaming at latency 1
    rst_n = 1'b1;
    tick(6);
    p0 = pop_cnt;
    tick(10);
    check_eq("t1_throughput", 32'(pop_cnt - p0), 32'd10);
    check_eq("t1_first_req", first_req_addr, RESET_PC);

    // Back-pressure: credit limit then exactly one refill per pop
    instr_ready = 1'b0;
    apply_reset();
    tick(12);
    check_eq("t2_req_cnt", 32'(req_cnt), 32'(DEPTH));
    check_eq("t2_req_stall", 32'(mem_req_valid), 32'd0);
    check_eq("t2_instr_valid", 32'(instr_valid), 32'd1);
    r0 = req_cnt;
    instr_ready = 1'b1;
    tick(1);
    instr_ready = 1'b0;
    tick(1);
    check_eq("t2_refill_next", 32'(req_cnt), 32'(r0 + 1));
    tick(5);
    check_eq("t2_refill_once", 32'(req_cnt), 32'(r0 + 1));

    // Redirect with two fetches in flight
    mem_req_ready = 1'b0;
    instr_ready   = 1'b1;
    rsp_lat       = 5;
    apply_reset();
    tick(2);
    redirect_to(32'h10);
    mem_req_ready = 1'b1;
    tick(2);
    mem_req_ready = 1'b0;
    redirect_to(32'h100);
    mem_req_ready = 1'b1;
    cap_idx = 0;
    check_eq("t3_drop_cnt", 32'(dut.drop_cnt_q), 32'd2);
    check_eq("t3_state_drain", 32'(dut.state_q), 32'd1);
    tick(3);
    check_eq("t3_drop_one_left", 32'(dut.drop_cnt_q), 32'd1);
    tick(1);
    check_eq("t3_drop_done", 32'(dut.drop_cnt_q), 32'd0);
    check_eq("t3_state_run", 32'(dut.state_q), 32'd0);
    tick(11);
    check_eq("t3_first_pc", cap_pc[0], 32'h100);
    check_eq("t3_second_pc", cap_pc[1], 32'h104);

    // Redirect coincident with a response, unaligned target
    mem_req_ready = 1'b0;
    rsp_lat       = 2;
    apply_reset();
    tick(2);
    redirect_to(32'h20);
    mem_req_ready = 1'b1;
    tick(2);
    mem_req_ready  = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    #1;
    check_eq("t4_rsp_coincident", 32'(mem_rsp_valid), 32'd1);
    tick(1);
    redirect_valid = 1'b0;
    mem_req_ready  = 1'b1;
    cap_idx = 0;
    check_eq("t4_drop_cnt", 32'(dut.drop_cnt_q), 32'd1);
    check_eq("t4_req_addr", mem_req_addr, 32'h200);
    tick(10);
    check_eq("t4_first_pc", cap_pc[0], 32'h200);
    check_eq("t4_second_pc", cap_pc[1], 32'h204);

    // Address wrap at the top of memory
    rsp_lat = 1;
    redirect_to(32'hFFFF_FFF8);
    cap_idx = 0;
    tick(10);
    check_eq("t5_pc0", cap_pc[0], 32'hFFFF_FFF8);
    check_eq("t5_pc1", cap_pc[1], 32'hFFFF_FFFC);
    check_eq("t5_pc2", cap_pc[2], 32'h0000_0000);

    // Reset in the middle of traffic
    instr_ready = 1'b0;
    tick(10);
    check_eq("t6_full_stall", 32'(mem_req_valid), 32'd0);
    check_eq("t6_full_count", 32'(dut.fifo_count_q), 32'(DEPTH));
    rsp_lat     = 10;
    instr_ready = 1'b1;
    tick(2);
    instr_ready = 1'b0;
    tick(3);
    check_eq("t6_outstanding", 32'(dut.outstanding_q), 32'd2);
    rst_n = 1'b0;
    #1;
    check_eq("t6_rst_instr_valid", 32'(instr_valid), 32'd0);
    check_eq("t6_rst_req_valid", 32'(mem_req_valid), 32'd0);
    tick(2);
    rsp_lat       = 1;
    mem_req_ready = 1'b1;
    instr_ready   = 1'b1;
    rst_n         = 1'b1;
    w = 0;
    while (req_cnt == 0 && w < 20) begin
      tick(1);
      w++;
    end
    check_eq("t6_first_req_seen", 32'(req_cnt > 0), 32'd1);
    check_eq("t6_first_req_addr", first_req_addr, RESET_PC);
    tick(6);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Watchdog against a stalled run
  initial begin
    #100000;
    n_fail++;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
